// File: rtl/counter_pkg.sv
// Shared constants for the multi-digit counter: modulus selection and the
// active-low 7-segment patterns (bit 7 is the dot).
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_8    = 2'b00,
    MODE_10   = 2'b01,
    MODE_16   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  // Hex letters keep the dot lit so they are not confused with digits.
  localparam logic [7:0] SEG_A     = 8'h08;
  localparam logic [7:0] SEG_B     = 8'h00;
  localparam logic [7:0] SEG_C     = 8'h46;
  localparam logic [7:0] SEG_D     = 8'h40;
  localparam logic [7:0] SEG_E     = 8'h06;
  localparam logic [7:0] SEG_F     = 8'h0E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Largest legal digit value; the reserved mode keeps whatever was in force.
  function automatic logic [3:0] mod_max(input mode_e mode, input logic [3:0] cur_max);
    case (mode)
      MODE_8:  return 4'd7;
      MODE_10: return 4'd9;
      MODE_16: return 4'd15;
      default: return cur_max;
    endcase
  endfunction

endpackage

// File: rtl/multi_digit_counter_seg_scan.sv
// Display scanner: walks the digit select across the display and registers
// the decoded segment pattern of the selected digit.
module seg_scan
  import counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [4*DIGITS-1:0]   count_i,
  output logic [7:0]            seg_data_o,
  output logic [DIGITS-1:0]     seg_cs_o
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        digit;
  logic [7:0]        pattern;
  logic [DIGITS-1:0] cs_sel;
  logic [7:0]        seg_data_q, seg_data_d;
  logic [DIGITS-1:0] seg_cs_q, seg_cs_d;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    if (en_i) begin
      if (scan_q == SCAN_LAST) begin
        scan_d = '0;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end
  end

  always_comb begin
    digit  = 4'd0;
    cs_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cs_sel[i] = (idx_q == IDX_W'(i));
      if (idx_q == IDX_W'(i)) digit = count_i[4*i +: 4];
    end
  end

  always_comb begin
    pattern = SEG_BLANK;
    case (digit)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_BLANK;
    endcase
    seg_data_d = en_i ? pattern : SEG_BLANK;
    seg_cs_d   = en_i ? cs_sel  : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q     <= '0;
      idx_q      <= '0;
      seg_data_q <= SEG_BLANK;
      seg_cs_q   <= '0;
    end else begin
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      seg_data_q <= seg_data_d;
      seg_cs_q   <= seg_cs_d;
    end
  end

  assign seg_data_o = seg_data_q;
  assign seg_cs_o   = seg_cs_q;

endmodule

// File: rtl/multi_digit_counter.sv
// N-digit cascaded up/down counter with selectable digit modulus, load
// clamping, wrap pulse and a scanned active-low 7-segment display.
module multi_digit_counter
  import counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100,
  parameter int SCAN_DIV = 8
) (
  input  logic                sys_clk_in,
  input  logic                sys_rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                dir,
  input  logic [1:0]          mode,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic [7:0]          seg_data,
  output logic [DIGITS-1:0]   seg_cs
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [1:0]          mode_q;
  logic [3:0]          max_q, max_cur;
  logic                mode_chg;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                tick;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                tc_q, tc_d;
  logic                carry;
  logic [3:0]          dig, lim, ld;

  always_comb begin
    max_cur  = mod_max(mode_e'(mode), max_q);
    mode_chg = (mode != mode_q);
    tick     = en && (tick_q == TICK_LAST);
    if (mode_chg || load) tick_d = '0;
    else if (en)          tick_d = tick ? '0 : tick_q + 1'b1;
    else                  tick_d = tick_q;
  end

  // carry means "every lower digit sits at its limit", so the current digit steps.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    carry   = 1'b1;
    dig     = 4'd0;
    lim     = 4'd0;
    ld      = 4'd0;
    if (mode_chg) begin
      count_d = '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        ld = load_val[4*i +: 4];
        count_d[4*i +: 4] = (ld > max_cur) ? max_cur : ld;
      end
    end else if (tick && (mode_e'(mode) != MODE_HOLD)) begin
      lim = dir ? max_cur : 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
        dig = count_q[4*i +: 4];
        if (carry) begin
          if (dir) count_d[4*i +: 4] = (dig == max_cur) ? 4'd0 : dig + 4'd1;
          else     count_d[4*i +: 4] = (dig == 4'd0) ? max_cur : dig - 4'd1;
        end
        carry = carry && (dig == lim);
      end
      tc_d = carry;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of statements or processes.
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q  <= MODE_8;
      max_q   <= 4'd7;
      tick_q  <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      mode_q  <= mode;
      max_q   <= max_cur;
      tick_q  <= tick_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

  seg_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk        (sys_clk_in),
    .rst_n      (sys_rst_n),
    .en_i       (en),
    .count_i    (count_q),
    .seg_data_o (seg_data),
    .seg_cs_o   (seg_cs)
  );

endmodule

// File: tb/tb_multi_digit_counter.sv
// Scoreboard bench: the driver runs an integer-valued reference counter and
// queues the expected outputs; a monitor compares after every clock edge.
module tb_multi_digit_counter;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int W        = 4 * DIGITS;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h08, 8'h00, 8'h46, 8'h40, 8'h06, 8'h0E
  };

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              load = 1'b0;
  logic [W-1:0]      load_val = '0;
  logic              dir = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [W-1:0]      count;
  logic              tc;
  logic [7:0]        seg_data;
  logic [DIGITS-1:0] seg_cs;

  multi_digit_counter #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .sys_clk_in (clk),
    .sys_rst_n  (rst_n),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .dir        (dir),
    .mode       (mode),
    .count      (count),
    .tc         (tc),
    .seg_data   (seg_data),
    .seg_cs     (seg_cs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]      count;
    logic              tc;
    logic [7:0]        seg_data;
    logic [DIGITS-1:0] seg_cs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: the counter is one integer in base m_cnt.
  int m_v, m_cnt, m_prev, m_modeq, m_tick, m_scan;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int pow_md(input int m);
    int p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * m;
    return p;
  endfunction

  function automatic logic [W-1:0] to_digits(input int v, input int m);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % m);
      v = v / m;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_v = 0; m_cnt = 8; m_prev = 8; m_modeq = 0; m_tick = 0; m_scan = 0;
  endtask

  // Predict the outputs after the next edge, queue them, then advance one cycle.
  task automatic step();
    exp_t         e;
    int           m, mpow, idx, d;
    bit           tk, tcn, mchg;
    logic [W-1:0] cur;
    m    = (mode == 2'd3) ? m_prev : (mode == 2'd0) ? 8 : (mode == 2'd1) ? 10 : 16;
    idx  = m_scan / SCAN_DIV;
    cur  = to_digits(m_v, m_cnt);
    mchg = (int'(mode) != m_modeq);
    tk   = en && (m_tick == TICK_DIV - 1);
    tcn  = 1'b0;
    e.seg_data = en ? SEG_TAB[cur[4*idx +: 4]] : 8'hFF;
    e.seg_cs   = en ? (DIGITS'(1) << idx) : '0;
    if (mchg) begin
      m_v = 0; m_cnt = m;
    end else if (load) begin
      m_v = 0; m_cnt = m;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        d = int'(load_val[4*i +: 4]);
        if (d > m - 1) d = m - 1;
        m_v = m_v * m + d;
      end
    end else if (tk && mode != 2'd3) begin
      mpow = pow_md(m_cnt);
      if (dir) begin tcn = (m_v == mpow - 1); m_v = (m_v + 1) % mpow; end
      else     begin tcn = (m_v == 0);        m_v = (m_v + mpow - 1) % mpow; end
    end
    if (mchg || load) m_tick = 0;
    else if (en)      m_tick = tk ? 0 : m_tick + 1;
    if (en) m_scan = (m_scan + 1) % (SCAN_DIV * DIGITS);
    m_modeq = int'(mode);
    m_prev  = m;
    e.count = to_digits(m_v, m_cnt);
    e.tc    = tcn;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", count, e.count);
        check("tc", tc, e.tc);
        check("seg_data", seg_data, e.seg_data);
        check("seg_cs", seg_cs, e.seg_cs);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    model_reset();
    #12;
    check("reset count", count, 0);
    check("reset tc", tc, 0);
    check("reset seg_data", seg_data, 8'hFF);
    check("reset seg_cs", seg_cs, 0);
    rst_n = 1'b1;

    // Decimal up-count through the full wrap.
    en = 1'b1; mode = 2'b01; dir = 1'b1;
    step();
    load = 1'b1; load_val = 8'h98; step(); load = 1'b0;
    check("load 98", count, 8'h98);
    run(4);
    check("up to 99", count, 8'h99);
    run(4);
    check("wrap to 00", count, 8'h00);
    check("wrap tc", tc, 1);
    step();
    check("tc one cycle", tc, 0);

    // Octal down-count wrapping from 00.
    mode = 2'b00; dir = 1'b0; step();
    load = 1'b1; load_val = 8'h00; step(); load = 1'b0;
    run(4);
    check("down wrap 77", count, 8'h77);
    check("down wrap tc", tc, 1);
    run(4);
    check("down 76", count, 8'h76);

    // Load clamping in decimal vs hex.
    mode = 2'b01; step();
    load = 1'b1; load_val = 8'hAF; step();
    check("clamp 99", count, 8'h99);
    mode = 2'b10; step(); step(); load = 1'b0;
    check("hex load AF", count, 8'hAF);

    // Mode change mid-count clears and restarts the tick divider.
    load = 1'b1; load_val = 8'h35; step(); load = 1'b0;
    dir = 1'b1; run(2);
    mode = 2'b01; step();
    check("mode change clear", count, 8'h00);
    run(3);
    check("no early tick", count, 8'h00);
    step();
    check("first tick after clear", count, 8'h01);

    // Freeze and blank, then resume scanning.
    load = 1'b1; load_val = 8'h12; step(); load = 1'b0;
    en = 1'b0; run(20);
    check("frozen count", count, 8'h12);
    check("blank seg_data", seg_data, 8'hFF);
    check("blank seg_cs", seg_cs, 0);
    en = 1'b1; run(8);

    // Randomised traffic including the reserved hold mode.
    for (int k = 0; k < 300; k++) begin
      en       = ($urandom_range(0, 9) != 0);
      dir      = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      step();
    end
    load = 1'b0;

    // Asynchronous reset between edges while counting.
    en = 1'b1; dir = 1'b1; mode = 2'b01; run(10);
    #4;
    rst_n = 1'b0;
    #1;
    check("async rst count", count, 0);
    check("async rst tc", tc, 0);
    check("async rst seg_data", seg_data, 8'hFF);
    check("async rst seg_cs", seg_cs, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run(9);
    check("restart count", count, 8'h02);

    repeat (2) @(posedge clk);
    #3;
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
